sc_statemachine_game: RTL and testbench

Parametrised general game controller for the Frogger datapath. It replaces the fixed-count general state machine with internal lives and level counters, a start-button edge detector, and a timed respawn phase. It also adds explicit WIN/LOSE terminal states with restart. It sits between the collision/goal detectors and the board loader, and drives the score/lives display and the board reload strobe.

---
 rtl/sc_statemachine_game.sv | 119 +++++++++++
 tb/tb_sc_statemachine_game.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_statemachine_game.sv
// General game controller for the Frogger datapath: lives/level bookkeeping,
// start-button edge detection, timed respawn and WIN/LOSE terminal states.
module sc_statemachine_game #(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_WIDTH    = 3,
  parameter int NUM_LEVELS     = 5,
  parameter int LEVEL_WIDTH    = 3,
  parameter int RESPAWN_CYCLES = 4,
  parameter int RESPAWN_WIDTH  = 3
) (
  input  logic                   SC_STATEMACHINEGAME_CLOCK_50,
  input  logic                   SC_STATEMACHINEGAME_RESET_InLow,
  input  logic                   SC_STATEMACHINEGAME_startButton_InLow,
  input  logic                   SC_STATEMACHINEGAME_Hit_InLow,
  input  logic                   SC_STATEMACHINEGAME_ReachTop_InLow,
  output logic [LIVES_WIDTH-1:0] SC_STATEMACHINEGAME_Lives_Out,
  output logic [LEVEL_WIDTH-1:0] SC_STATEMACHINEGAME_Level_Out,
  output logic                   SC_STATEMACHINEGAME_Load_OutLow,
  output logic                   SC_STATEMACHINEGAME_Playing_Out,
  output logic                   SC_STATEMACHINEGAME_Win_Out,
  output logic                   SC_STATEMACHINEGAME_Lose_Out,
  output logic [2:0]             SC_STATEMACHINEGAME_State_Out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PLAY     = 3'd2,
    S_DEATH    = 3'd3,
    S_RESPAWN  = 3'd4,
    S_LEVEL_UP = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  localparam logic [LIVES_WIDTH-1:0]   LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0]   LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]   LEVEL_LAST = LEVEL_WIDTH'(NUM_LEVELS - 1);
  localparam logic [RESPAWN_WIDTH-1:0] RESP_LAST  = RESPAWN_WIDTH'(RESPAWN_CYCLES - 1);

  state_t                   state;
  logic [LIVES_WIDTH-1:0]   lives;
  logic [LEVEL_WIDTH-1:0]   level;
  logic [RESPAWN_WIDTH-1:0] resp_cnt;
  logic                     start_prev;
  logic                     press;
  logic                     hit;
  logic                     reach;

  // A press is the high-to-low transition of the button, so holding it counts once.
  assign press = start_prev & ~SC_STATEMACHINEGAME_startButton_InLow;
  assign hit   = ~SC_STATEMACHINEGAME_Hit_InLow;
  assign reach = ~SC_STATEMACHINEGAME_ReachTop_InLow;

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or negedge SC_STATEMACHINEGAME_RESET_InLow) begin
    if (!SC_STATEMACHINEGAME_RESET_InLow) begin
      state      <= S_IDLE;
      lives      <= LIVES_LOAD;
      level      <= '0;
      resp_cnt   <= '0;
      start_prev <= 1'b1;
    end else begin
      start_prev <= SC_STATEMACHINEGAME_startButton_InLow;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (press) begin
            lives <= LIVES_LOAD;
            level <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_PLAY;
        S_PLAY: begin
          if (hit) begin
            state <= S_DEATH;
          end else if (reach) begin
            state <= S_LEVEL_UP;
          end
        end
        S_DEATH: begin
          // Saturate at zero; the last life (or none) ends the game.
          if (lives != '0) begin
            lives <= lives - LIVES_ONE;
          end
          if (lives <= LIVES_ONE) begin
            state <= S_LOSE;
          end else begin
            resp_cnt <= '0;
            state    <= S_RESPAWN;
          end
        end
        S_RESPAWN: begin
          resp_cnt <= resp_cnt + 1'b1;
          if (resp_cnt == RESP_LAST) begin
            state <= S_LOAD;
          end
        end
        S_LEVEL_UP: begin
          if (level == LEVEL_LAST) begin
            state <= S_WIN;
          end else begin
            level <= level + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign SC_STATEMACHINEGAME_Lives_Out    = lives;
  assign SC_STATEMACHINEGAME_Level_Out    = level;
  assign SC_STATEMACHINEGAME_Load_OutLow  = (state != S_LOAD);
  assign SC_STATEMACHINEGAME_Playing_Out  = (state == S_PLAY);
  assign SC_STATEMACHINEGAME_Win_Out      = (state == S_WIN);
  assign SC_STATEMACHINEGAME_Lose_Out     = (state == S_LOSE);
  assign SC_STATEMACHINEGAME_State_Out    = state;

endmodule

// File: tb/tb_sc_statemachine_game.sv
// Bench for sc_statemachine_game: directed scenarios plus random play, all
// compared against a trace model that expands game events into per-cycle snapshots.
module tb_sc_statemachine_game;

  localparam int LI = 3;
  localparam int NL = 5;
  localparam int RC = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2, S_DEATH = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4, S_LVUP = 3'd5, S_WIN = 3'd6, S_LOSE = 3'd7;
  localparam logic [12:0] RESET_VEC = {3'd0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b1;
  logic       hit_n = 1'b1;
  logic       reach_n = 1'b1;
  logic [2:0] lives_o;
  logic [2:0] level_o;
  logic [2:0] state_o;
  logic       load_n;
  logic       playing;
  logic       win;
  logic       lose;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sc_statemachine_game #(
    .LIVES_INIT(LI), .LIVES_WIDTH(3), .NUM_LEVELS(NL),
    .LEVEL_WIDTH(3), .RESPAWN_CYCLES(RC), .RESPAWN_WIDTH(3)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50(clk),
    .SC_STATEMACHINEGAME_RESET_InLow(rst_n),
    .SC_STATEMACHINEGAME_startButton_InLow(btn),
    .SC_STATEMACHINEGAME_Hit_InLow(hit_n),
    .SC_STATEMACHINEGAME_ReachTop_InLow(reach_n),
    .SC_STATEMACHINEGAME_Lives_Out(lives_o),
    .SC_STATEMACHINEGAME_Level_Out(level_o),
    .SC_STATEMACHINEGAME_Load_OutLow(load_n),
    .SC_STATEMACHINEGAME_Playing_Out(playing),
    .SC_STATEMACHINEGAME_Win_Out(win),
    .SC_STATEMACHINEGAME_Lose_Out(lose),
    .SC_STATEMACHINEGAME_State_Out(state_o)
  );

  // Reference model: the current snapshot {state, lives, level} plus a queue of
  // snapshots already committed by a game event (press, hit, goal).
  logic [2:0] cur_st;
  logic [2:0] cur_lives;
  logic [2:0] cur_level;
  logic       prev_btn;
  logic [8:0] exp_q[$];

  task automatic model_reset();
    exp_q.delete();
    cur_st = S_IDLE;
    cur_lives = 3'(LI);
    cur_level = 3'd0;
    prev_btn = 1'b1;
  endtask

  task automatic model_step(input logic b, input logic h, input logic r);
    logic       press;
    logic [2:0] nl;
    logic [8:0] snap;
    press = prev_btn & ~b;
    prev_btn = b;
    if (exp_q.size() == 0) begin
      if (cur_st == S_IDLE || cur_st == S_WIN || cur_st == S_LOSE) begin
        if (press) begin
          exp_q.push_back({S_LOAD, 3'(LI), 3'd0});
          exp_q.push_back({S_PLAY, 3'(LI), 3'd0});
        end
      end else if (cur_st == S_PLAY) begin
        if (!h) begin
          nl = (cur_lives == 3'd0) ? 3'd0 : cur_lives - 3'd1;
          exp_q.push_back({S_DEATH, cur_lives, cur_level});
          if (cur_lives <= 3'd1) begin
            exp_q.push_back({S_LOSE, nl, cur_level});
          end else begin
            for (int i = 0; i < RC; i++) exp_q.push_back({S_RESP, nl, cur_level});
            exp_q.push_back({S_LOAD, nl, cur_level});
            exp_q.push_back({S_PLAY, nl, cur_level});
          end
        end else if (!r) begin
          exp_q.push_back({S_LVUP, cur_lives, cur_level});
          if (cur_level == 3'(NL - 1)) begin
            exp_q.push_back({S_WIN, cur_lives, cur_level});
          end else begin
            exp_q.push_back({S_LOAD, cur_lives, cur_level + 3'd1});
            exp_q.push_back({S_PLAY, cur_lives, cur_level + 3'd1});
          end
        end
      end
    end
    if (exp_q.size() != 0) begin
      snap = exp_q.pop_front();
      {cur_st, cur_lives, cur_level} = snap;
    end
  endtask

  function automatic logic [12:0] exp_vec();
    return {cur_st, cur_lives, cur_level, cur_st != S_LOAD, cur_st == S_PLAY,
            cur_st == S_WIN, cur_st == S_LOSE};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {state_o, lives_o, level_o, load_n, playing, win, lose};
  endfunction

  // Drive one clock of inputs; returns at the following falling edge.
  task automatic cycle(input logic b, input logic h, input logic r);
    btn = b;
    hit_n = h;
    reach_n = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(b, h, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn = 1'b1; hit_n = 1'b1; reach_n = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_game();
    do_reset();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      total++;
      if (dut_vec() !== RESET_VEC || exp_vec() !== RESET_VEC) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dut_vec(), RESET_VEC);
      end
    end
  endtask

  task automatic test_start_held();
    int loads = 0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      // held 10 cycles, released 4, re-pressed 4 in PLAY, released again
      cycle((i < 10) || (i >= 14 && i < 18) ? 1'b0 : 1'b1, 1'b1, 1'b1);
      if (!load_n) loads++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL start_held cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i == 9) begin
        total++;
        if (state_o !== S_PLAY || loads != 1) begin
          bad++;
          $display("FAIL start_held_play state=%0d loads=%0d exp state=2 loads=1", state_o, loads);
        end
      end
    end
    total++;
    if (loads != 1) begin
      bad++;
      $display("FAIL start_single_load loads=%0d exp=1", loads);
    end
  endtask

  task automatic test_hit();
    int loads = 0, deaths = 0, resp = 0;
    start_game();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cycle(1'b1, 1'b1, 1'b1);
      if (!load_n) loads++;
      if (state_o == S_DEATH) deaths++;
      if (state_o == S_RESP) resp++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL hit_trace cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (deaths != 1 || resp != RC || loads != 1 || state_o !== S_PLAY ||
        lives_o !== 3'd2 || level_o !== 3'd0) begin
      bad++;
      $display("FAIL hit_summary death=%0d resp=%0d loads=%0d st=%0d lives=%0d lvl=%0d exp 1 4 1 2 2 0",
               deaths, resp, loads, state_o, lives_o, level_o);
    end
  endtask

  task automatic test_lose();
    int loads = 0;
    start_game();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12 && cur_st != S_PLAY && cur_st != S_LOSE; i++) begin
        cycle(1'b1, 1'b1, 1'b1);
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL lose_trace hit=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
        end
      end
    end
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      total++;
      if (state_o !== S_LOSE || lose !== 1'b1 || lives_o !== 3'd0 || playing !== 1'b0) begin
        bad++;
        $display("FAIL lose_hold cyc=%0d st=%0d lose=%b lives=%0d exp 7 1 0", i, state_o, lose, lives_o);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0 ? 1'b0 : 1'b1, 1'b1, 1'b1);
      if (!load_n) loads++;
    end
    total++;
    if (state_o !== S_PLAY || lives_o !== 3'd3 || level_o !== 3'd0 || loads != 1) begin
      bad++;
      $display("FAIL lose_restart st=%0d lives=%0d lvl=%0d loads=%0d exp 2 3 0 1", state_o, lives_o, level_o, loads);
    end
  endtask

  task automatic test_level();
    int loads = 0;
    start_game();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8 && cur_st != S_PLAY && cur_st != S_WIN; i++) begin
        cycle(1'b1, 1'b1, 1'b1);
        if (!load_n) loads++;
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL level_trace goal=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
        end
      end
      if (k < 4) begin
        total++;
        if (level_o !== 3'(k + 1) || state_o !== S_PLAY) begin
          bad++;
          $display("FAIL level_step goal=%0d lvl=%0d st=%0d exp lvl=%0d st=2", k, level_o, state_o, k + 1);
        end
      end
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    total++;
    if (state_o !== S_WIN || win !== 1'b1 || level_o !== 3'd4 || loads != 4) begin
      bad++;
      $display("FAIL level_win st=%0d win=%b lvl=%0d loads=%0d exp 6 1 4 4", state_o, win, level_o, loads);
    end
  endtask

  task automatic test_both_then_reset();
    int loads = 0;
    start_game();
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (state_o !== S_DEATH || level_o !== 3'd0 || dut_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL hit_priority st=%0d lvl=%0d exp st=3 lvl=0", state_o, level_o);
    end
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    total++;
    if (dut_vec() !== exp_vec() || state_o !== S_RESP) begin
      bad++;
      $display("FAIL respawn_c2 got=%h exp=%h", dut_vec(), exp_vec());
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (!load_n) loads++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (loads != 0) begin
      bad++;
      $display("FAIL post_reset_load loads=%0d exp=0", loads);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 5) != 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_held();
    test_hit();
    test_lose();
    test_level();
    test_both_then_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
